// File: rtl/sprite_reg_arbiter.sv
// Arbitrates one sprite register-file port between CPU accesses and a per-frame
// snapshot engine that reads registers 0..NUM_REGS-1, with a bounded starvation guarantee.
module sprite_reg_arbiter #(
  parameter int NUM_REGS     = 17,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic [5:0] cpu_addr,
  input  logic       cpu_we,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic [7:0] cpu_rdata,
  output logic       cpu_rvalid,
  input  logic       frame_start,
  output logic       snap_busy,
  output logic       snap_valid,
  output logic [4:0] snap_idx,
  output logic [7:0] snap_data,
  output logic       snap_done,
  output logic       snap_miss,
  output logic [5:0] reg_addr,
  output logic       reg_we,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata
);

  localparam int              CNT_W      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [4:0]      LAST_IDX   = 5'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, SNAP = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [7:0]       cpu_rdata_q, cpu_rdata_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             snap_valid_q, snap_valid_d;
  logic [4:0]       snap_idx_q, snap_idx_d;
  logic [7:0]       snap_data_q, snap_data_d;
  logic             snap_done_q, snap_done_d;
  logic             snap_miss_q, snap_miss_d;
  logic             engine_req, engine_force, engine_win;

  // Busy spans the whole snapshot including the trailing done pulse, so a
  // frame_start landing on the done pulse is reported as a miss, not a restart.
  assign snap_busy  = (state_q != IDLE) | snap_done_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign snap_valid = snap_valid_q;
  assign snap_idx   = snap_idx_q;
  assign snap_data  = snap_data_q;
  assign snap_done  = snap_done_q;
  assign snap_miss  = snap_miss_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start && !snap_busy) state_d = SNAP; else state_d = IDLE;
      SNAP:    if (engine_win && (idx_q == LAST_IDX)) state_d = DONE; else state_d = SNAP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    engine_req   = (state_q == SNAP);
    engine_force = engine_req && (starve_q == STARVE_MAX);
    cpu_gnt      = cpu_req && !engine_force;
    engine_win   = engine_req && !cpu_gnt;
    if (cpu_gnt) begin
      reg_addr  = cpu_addr;
      reg_we    = cpu_we;
      reg_wdata = cpu_wdata;
    end else if (engine_win) begin
      reg_addr  = {1'b0, idx_q};
      reg_we    = 1'b0;
      reg_wdata = 8'h00;
    end else begin
      reg_addr  = 6'd0;
      reg_we    = 1'b0;
      reg_wdata = 8'h00;
    end
  end

  always_comb begin
    idx_d    = idx_q;
    starve_d = starve_q;
    if ((state_q == IDLE) && frame_start && !snap_busy) begin
      idx_d    = 5'd0;
      starve_d = '0;
    end else if (engine_win) begin
      idx_d    = idx_q + 5'd1;
      starve_d = '0;
    end else if (engine_req) begin
      starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = starve_q;
    end
    cpu_rvalid_d = cpu_gnt && !cpu_we;
    cpu_rdata_d  = cpu_rvalid_d ? reg_rdata : cpu_rdata_q;
    snap_valid_d = engine_win;
    snap_idx_d   = engine_win ? idx_q : snap_idx_q;
    snap_data_d  = engine_win ? reg_rdata : snap_data_q;
    snap_done_d  = (state_q == DONE);
    snap_miss_d  = frame_start && snap_busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= 5'd0;
      starve_q     <= '0;
      cpu_rdata_q  <= 8'h00;
      cpu_rvalid_q <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_idx_q   <= 5'd0;
      snap_data_q  <= 8'h00;
      snap_done_q  <= 1'b0;
      snap_miss_q  <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      starve_q     <= starve_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      snap_valid_q <= snap_valid_d;
      snap_idx_q   <= snap_idx_d;
      snap_data_q  <= snap_data_d;
      snap_done_q  <= snap_done_d;
      snap_miss_q  <= snap_miss_d;
    end
  end

endmodule
